reg_mux_nto1: RTL and testbench

Parametrised, registered N-to-1 operand-select mux for the MIPS pipeline, e.g. forwarding-path and ALU-source selection at a stage boundary. It selects one of N_IN words and captures it into a single pipeline register behind a valid/ready handshake. The register supports stall and flush. An out-of-range select is handled explicitly: the block re-issues the last good value and raises an error pulse plus a saturating error count.

---
 rtl/reg_mux_nto1.sv | 87 ++++++++
 tb/tb_reg_mux_nto1.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_mux_nto1.sv
// Registered N-to-1 operand-select mux with a valid/ready pipeline register.
// Out-of-range selects re-issue the last good word and are counted.
`timescale 1ns/1ps

module reg_mux_nto1 #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 3,
  parameter int SEL_W = 2
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [N_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [WIDTH-1:0]      out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err,
  output logic [7:0]            err_cnt
);

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_last_good;
  logic             r_out_valid;
  logic             r_sel_err;
  logic [7:0]       r_err_cnt;

  logic [WIDTH-1:0] w_sel_word;
  logic             w_sel_ok;
  logic             w_accept;

  // NOTE: both outputs get a value before the loop so no path leaves them
  // unassigned; otherwise synthesis would infer a latch to hold them.
  always_comb begin
    w_sel_word = '0;
    w_sel_ok   = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        w_sel_word = in_bus[k*WIDTH +: WIDTH];
        w_sel_ok   = 1'b1;
      end
    end
  end

  // in_ready depends only on registered state and the downstream/flush inputs.
  assign in_ready = !flush && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_out       <= '0;
      r_last_good <= '0;
      r_out_valid <= 1'b0;
      r_sel_err   <= 1'b0;
      r_err_cnt   <= 8'd0;
    end else begin
      r_sel_err <= 1'b0;
      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_valid <= 1'b1;
        if (w_sel_ok) begin
          r_out       <= w_sel_word;
          r_last_good <= w_sel_word;
        end else begin
          r_out     <= r_last_good;
          r_sel_err <= 1'b1;
          if (r_err_cnt != 8'hFF) begin
            r_err_cnt <= r_err_cnt + 8'd1;
          end
        end
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign sel_err   = r_sel_err;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_reg_mux_nto1.sv
// Self-checking bench for reg_mux_nto1: directed vector table, hand sequences
// and randomized traffic against a rule-level model, for two parameter sets.
`timescale 1ns/1ps

module tb_reg_mux_nto1;

  localparam int AW = 32, AN = 3, AS = 2;
  localparam int BW = 16, BN = 8, BS = 3;
  localparam logic [31:0] W0 = 32'h11111111, W1 = 32'h22222222, W2 = 32'h33333333;

  logic Clk = 1'b0;
  logic Rst;

  logic [31:0]      a_w [AN];
  logic [AN*AW-1:0] a_in_bus;
  logic [AS-1:0]    a_sel;
  logic             a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_sel_err;
  logic [AW-1:0]    a_out;
  logic [7:0]       a_err_cnt;

  logic [15:0]      b_w [BN];
  logic [BN*BW-1:0] b_in_bus;
  logic [BS-1:0]    b_sel;
  logic             b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_sel_err;
  logic [BW-1:0]    b_out;
  logic [7:0]       b_err_cnt;

  assign a_in_bus = {a_w[2], a_w[1], a_w[0]};
  assign b_in_bus = {b_w[7], b_w[6], b_w[5], b_w[4], b_w[3], b_w[2], b_w[1], b_w[0]};

  reg_mux_nto1 #(.WIDTH(AW), .N_IN(AN), .SEL_W(AS)) u_dut_a (
    .Clk(Clk), .Rst(Rst), .in_bus(a_in_bus), .sel(a_sel), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .flush(a_flush), .out(a_out), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .sel_err(a_sel_err), .err_cnt(a_err_cnt)
  );

  reg_mux_nto1 #(.WIDTH(BW), .N_IN(BN), .SEL_W(BS)) u_dut_b (
    .Clk(Clk), .Rst(Rst), .in_bus(b_in_bus), .sel(b_sel), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .flush(b_flush), .out(b_out), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .sel_err(b_sel_err), .err_cnt(b_err_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        iv;
    logic [3:0]  sel;
    logic        ordy;
    logic        fl;
    logic        x_ir;
    logic [31:0] x_out;
    logic        x_v;
    logic        x_err;
    logic [8:0]  x_cnt;
  } vec_t;

  typedef struct packed {
    logic [63:0] out;
    logic        valid;
    logic [63:0] last;
    logic        err;
    logic [8:0]  cnt;
  } model_t;

  vec_t   vecs [24];
  model_t ma, mb;
  int     n_checks = 0;
  int     n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic iv, input int sel, input logic ordy, input logic fl,
                              input logic ir, input logic [31:0] o, input logic v,
                              input logic e, input int c);
    vec_t r;
    r.iv = iv; r.sel = 4'(sel); r.ordy = ordy; r.fl = fl;
    r.x_ir = ir; r.x_out = o; r.x_v = v; r.x_err = e; r.x_cnt = 9'(c);
    return r;
  endfunction

  // Reference behaviour written directly from the handshake/select rules.
  function automatic logic model_ready(input model_t m, input logic ordy, input logic fl);
    return !fl && (!m.valid || ordy);
  endfunction

  function automatic model_t model_step(input model_t m, input int sel, input int n,
                                        input logic [63:0] word_sel, input logic iv,
                                        input logic ordy, input logic fl);
    model_t r;
    r = m;
    r.err = 1'b0;
    if (fl) begin
      r.valid = 1'b0;
    end else if (iv && model_ready(m, ordy, fl)) begin
      r.valid = 1'b1;
      if (sel < n) begin
        r.out  = word_sel;
        r.last = word_sel;
      end else begin
        r.out = m.last;
        r.err = 1'b1;
        r.cnt = (m.cnt < 255) ? m.cnt + 9'd1 : 9'd255;
      end
    end else if (ordy) begin
      r.valid = 1'b0;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive_a(input logic iv, input int sel, input logic ordy, input logic fl);
    a_in_valid  = iv;
    a_sel       = sel[AS-1:0];
    a_out_ready = ordy;
    a_flush     = fl;
  endtask

  task automatic drive_b(input logic iv, input int sel, input logic ordy, input logic fl);
    b_in_valid  = iv;
    b_sel       = sel[BS-1:0];
    b_out_ready = ordy;
    b_flush     = fl;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    tick();
    tick();
    Rst = 1'b0;
    ma = '0;
    mb = '0;
  endtask

  task automatic check_a(input string tag, input model_t m);
    check($sformatf("%s a.out", tag),       64'(a_out),       m.out);
    check($sformatf("%s a.out_valid", tag), 64'(a_out_valid), 64'(m.valid));
    check($sformatf("%s a.sel_err", tag),   64'(a_sel_err),   64'(m.err));
    check($sformatf("%s a.err_cnt", tag),   64'(a_err_cnt),   64'(m.cnt));
  endtask

  task automatic check_b(input string tag, input model_t m);
    check($sformatf("%s b.out", tag),       64'(b_out),       m.out);
    check($sformatf("%s b.out_valid", tag), 64'(b_out_valid), 64'(m.valid));
    check($sformatf("%s b.sel_err", tag),   64'(b_sel_err),   64'(m.err));
    check($sformatf("%s b.err_cnt", tag),   64'(b_err_cnt),   64'(m.cnt));
  endtask

  initial begin
    int s;
    logic iv, ordy, fl;
    logic [63:0] wsel;

    //          iv sel ordy fl | ir out v err cnt
    vecs[0]  = mk(1, 3, 1, 0,  1, 32'h0, 1, 1, 1);
    vecs[1]  = mk(1, 2, 1, 0,  1, W2, 1, 0, 1);
    vecs[2]  = mk(0, 0, 1, 0,  1, W2, 0, 0, 1);
    vecs[3]  = mk(1, 1, 1, 0,  1, W1, 1, 0, 1);
    vecs[4]  = mk(1, 3, 1, 0,  1, W1, 1, 1, 2);
    vecs[5]  = mk(0, 0, 1, 0,  1, W1, 0, 0, 2);
    vecs[6]  = mk(1, 0, 1, 0,  1, W0, 1, 0, 2);
    vecs[7]  = mk(1, 2, 0, 0,  0, W0, 1, 0, 2);
    vecs[8]  = mk(1, 2, 0, 0,  0, W0, 1, 0, 2);
    vecs[9]  = mk(1, 2, 0, 0,  0, W0, 1, 0, 2);
    vecs[10] = mk(1, 2, 0, 0,  0, W0, 1, 0, 2);
    vecs[11] = mk(1, 2, 1, 0,  1, W2, 1, 0, 2);
    vecs[12] = mk(1, 0, 1, 0,  1, W0, 1, 0, 2);
    vecs[13] = mk(1, 1, 1, 0,  1, W1, 1, 0, 2);
    vecs[14] = mk(1, 2, 1, 0,  1, W2, 1, 0, 2);
    vecs[15] = mk(1, 0, 1, 0,  1, W0, 1, 0, 2);
    vecs[16] = mk(1, 1, 1, 0,  1, W1, 1, 0, 2);
    vecs[17] = mk(1, 2, 1, 0,  1, W2, 1, 0, 2);
    vecs[18] = mk(1, 0, 0, 0,  0, W2, 1, 0, 2);
    vecs[19] = mk(1, 0, 0, 1,  0, W2, 0, 0, 2);
    vecs[20] = mk(0, 0, 0, 0,  1, W2, 0, 0, 2);
    vecs[21] = mk(1, 1, 1, 1,  0, W2, 0, 0, 2);
    vecs[22] = mk(1, 3, 0, 0,  1, W2, 1, 1, 3);
    vecs[23] = mk(1, 0, 0, 1,  0, W2, 0, 0, 3);

    a_w[0] = W0; a_w[1] = W1; a_w[2] = W2;
    for (int k = 0; k < BN; k++) b_w[k] = 16'(k);
    drive_a(0, 0, 0, 0);
    drive_b(0, 0, 0, 0);
    do_reset();

    check_a("reset", ma);
    check_b("reset", mb);

    // Directed table
    for (int i = 0; i < 24; i++) begin
      drive_a(vecs[i].iv, int'(vecs[i].sel), vecs[i].ordy, vecs[i].fl);
      #1;
      check($sformatf("vec%0d in_ready", i), 64'(a_in_ready), 64'(vecs[i].x_ir));
      tick();
      check($sformatf("vec%0d out", i),       64'(a_out),       64'(vecs[i].x_out));
      check($sformatf("vec%0d out_valid", i), 64'(a_out_valid), 64'(vecs[i].x_v));
      check($sformatf("vec%0d sel_err", i),   64'(a_sel_err),   64'(vecs[i].x_err));
      check($sformatf("vec%0d err_cnt", i),   64'(a_err_cnt),   64'(vecs[i].x_cnt));
    end

    // Async reset in the middle of a stall, with no clock edge
    drive_a(1, 1, 0, 0);
    tick();
    drive_a(1, 2, 0, 0);
    tick();
    check("stall pre-reset out", 64'(a_out), 64'(W1));
    Rst = 1'b1;
    #1;
    check("async rst out",       64'(a_out),       64'h0);
    check("async rst out_valid", 64'(a_out_valid), 64'h0);
    check("async rst err_cnt",   64'(a_err_cnt),   64'h0);
    #1;
    Rst = 1'b0;
    ma = '0;
    mb = '0;
    drive_a(1, 3, 1, 0);
    tick();
    check("post-rst oor out",     64'(a_out),     64'h0);
    check("post-rst oor sel_err", 64'(a_sel_err), 64'h1);
    check("post-rst oor err_cnt", 64'(a_err_cnt), 64'h1);
    drive_a(0, 0, 1, 0);
    tick();
    check("post-rst sel_err clears", 64'(a_sel_err), 64'h0);

    // Saturation: 300 out-of-range accepts from reset
    do_reset();
    drive_a(1, 3, 1, 0);
    repeat (254) tick();
    check("sat cnt 254", 64'(a_err_cnt), 64'd254);
    tick();
    check("sat cnt 255", 64'(a_err_cnt), 64'd255);
    repeat (45) tick();
    check("sat cnt holds", 64'(a_err_cnt), 64'd255);
    check("sat sel_err",   64'(a_sel_err), 64'h1);
    check("sat out",       64'(a_out),     64'h0);

    // Randomized traffic on the 3-input instance
    drive_a(0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < AN; k++) a_w[k] = $urandom();
      s    = int'($urandom_range(0, 3));
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 9) < 7);
      fl   = ($urandom_range(0, 9) == 0);
      drive_a(iv, s, ordy, fl);
      #1;
      check($sformatf("rndA%0d in_ready", i), 64'(a_in_ready), 64'(model_ready(ma, ordy, fl)));
      wsel = (s < AN) ? 64'(a_w[s]) : 64'h0;
      tick();
      ma = model_step(ma, s, AN, wsel, iv, ordy, fl);
      check_a($sformatf("rndA%0d", i), ma);
    end
    drive_a(0, 0, 0, 0);

    // 8-input instance: every select value is in range
    do_reset();
    for (int k = 0; k < BN; k++) begin
      for (int j = 0; j < BN; j++) b_w[j] = 16'($urandom());
      wsel = 64'(b_w[k]);
      drive_b(1, k, 1, 0);
      tick();
      mb = model_step(mb, k, BN, wsel, 1'b1, 1'b1, 1'b0);
      check($sformatf("sweepB%0d out", k),     64'(b_out),     wsel);
      check($sformatf("sweepB%0d sel_err", k), 64'(b_sel_err), 64'h0);
    end
    for (int i = 0; i < 150; i++) begin
      for (int k = 0; k < BN; k++) b_w[k] = 16'($urandom());
      s    = int'($urandom_range(0, 7));
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 9) < 7);
      fl   = ($urandom_range(0, 9) == 0);
      drive_b(iv, s, ordy, fl);
      #1;
      check($sformatf("rndB%0d in_ready", i), 64'(b_in_ready), 64'(model_ready(mb, ordy, fl)));
      wsel = 64'(b_w[s]);
      tick();
      mb = model_step(mb, s, BN, wsel, iv, ordy, fl);
      check_b($sformatf("rndB%0d", i), mb);
    end
    drive_b(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
